// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices one code/dp bus across
// NUM_DIGITS common-anode digits with blanking, blink, PWM brightness and a dead cycle.
module sseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DATA_W       = 5,
  parameter int unsigned REFRESH_LOG2 = 17,
  parameter int unsigned BRIGHT_W     = 3,
  parameter int unsigned BLINK_LOG2   = 5,
  localparam int unsigned IdxW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_DIGITS*DATA_W-1:0]   digit_data_i,
  input  logic [NUM_DIGITS-1:0]          dp_in_i,
  input  logic [NUM_DIGITS-1:0]          blank_mask_i,
  input  logic [NUM_DIGITS-1:0]          blink_mask_i,
  input  logic [BRIGHT_W-1:0]            brightness_i,
  input  logic                           disp_en_i,
  output logic [DATA_W-1:0]              data_out_o,
  output logic                           dp_out_o,
  output logic [NUM_DIGITS-1:0]          anode_o,
  output logic [IdxW-1:0]                scan_idx_o
);

  logic [REFRESH_LOG2-1:0] presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BLINK_LOG2-1:0]   frame_q, frame_d;
  logic                    init_q;
  logic [DATA_W-1:0]       code_q, code_d;
  logic                    snap_dp_q, snap_dp_d;
  logic                    blank_q, blank_d;
  logic                    blink_q, blink_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    dp_out_q, dp_out_d;

  logic                    tc;
  logic                    load;
  logic [BRIGHT_W-1:0]     phase_d;
  logic                    lit_d;

  always_comb begin
    tc      = &presc_q;
    // The first cycle after reset also loads, so slot 0 shows live data.
    load    = tc | init_q;
    presc_d = presc_q + 1'b1;

    idx_d = idx_q;
    if (tc) begin
      idx_d = (idx_q == '0) ? IdxW'(NUM_DIGITS - 1) : idx_q - 1'b1;
    end
    frame_d = (tc && (idx_q == '0)) ? frame_q + 1'b1 : frame_q;

    code_d    = code_q;
    snap_dp_d = snap_dp_q;
    blank_d   = blank_q;
    blink_d   = blink_q;
    bright_d  = bright_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load && (idx_d == IdxW'(i))) begin
        code_d    = digit_data_i[i*DATA_W +: DATA_W];
        snap_dp_d = dp_in_i[i];
        blank_d   = blank_mask_i[i];
        blink_d   = blink_mask_i[i];
        bright_d  = brightness_i;
      end
    end

    // Outputs are registered from next-state values so they line up with scan_idx.
    phase_d = presc_d[REFRESH_LOG2-1 -: BRIGHT_W];
    lit_d   = disp_en_i & ~blank_d & ~(blink_d & frame_d[BLINK_LOG2-1]) &
              (presc_d != '0) & (phase_d <= bright_d);

    anode_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IdxW'(i)) begin
        anode_d[i] = ~lit_d;
      end
    end
    dp_out_d = ~(snap_dp_d & lit_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q   <= '0;
      idx_q     <= IdxW'(NUM_DIGITS - 1);
      frame_q   <= '0;
      init_q    <= 1'b1;
      code_q    <= '0;
      snap_dp_q <= 1'b0;
      blank_q   <= 1'b0;
      blink_q   <= 1'b0;
      bright_q  <= '0;
      anode_q   <= '1;
      dp_out_q  <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      init_q    <= 1'b0;
      code_q    <= code_d;
      snap_dp_q <= snap_dp_d;
      blank_q   <= blank_d;
      blink_q   <= blink_d;
      bright_q  <= bright_d;
      anode_q   <= anode_d;
      dp_out_q  <= dp_out_d;
    end
  end

  assign data_out_o = code_q;
  assign dp_out_o   = dp_out_q;
  assign anode_o    = anode_q;
  assign scan_idx_o = idx_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a slot/frame-arithmetic model predicts each cycle's
// outputs into a queue; a monitor pops and compares after every clock edge.
module tb_sseg_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int RL = 4;
  localparam int BW = 2;
  localparam int BL = 1;
  localparam int SLOT = 1 << RL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N*DW-1:0] digit_data = '0;
  logic [N-1:0]  dp_in = '0, blank_mask = '0, blink_mask = '0;
  logic [BW-1:0] brightness = '0;
  logic          disp_en = 1'b1;
  logic [DW-1:0] data_out;
  logic          dp_out;
  logic [N-1:0]  anode;
  logic [1:0]    scan_idx;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];
  int          tag_q[$];

  // Model state: edge count since reset release and the slot's captured inputs.
  int          k = 0;
  logic [DW-1:0] s_code;
  logic        s_dp, s_blank, s_blink;
  int          s_bright;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DATA_W      (DW),
    .REFRESH_LOG2(RL),
    .BRIGHT_W    (BW),
    .BLINK_LOG2  (BL)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .digit_data_i(digit_data),
    .dp_in_i     (dp_in),
    .blank_mask_i(blank_mask),
    .blink_mask_i(blink_mask),
    .brightness_i(brightness),
    .disp_en_i   (disp_en),
    .data_out_o  (data_out),
    .dp_out_o    (dp_out),
    .anode_o     (anode),
    .scan_idx_o  (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at a negedge: optionally randomise inputs, predict the next edge, wait a cycle.
  task automatic step(input bit rnd);
    int p, s, dig, boff;
    bit lit;
    logic [N-1:0] an;
    logic [1:0] di;
    if (rnd) begin
      digit_data = 20'($urandom);
      dp_in      = 4'($urandom);
      blank_mask = 4'($urandom) & 4'($urandom);
      blink_mask = 4'($urandom);
      brightness = 2'($urandom);
      disp_en    = ($urandom_range(0, 7) != 0);
    end
    k++;
    p    = k % SLOT;
    s    = k / SLOT;
    dig  = (N - 1) - (s % N);
    boff = (s / N) % 2;
    if (k == 1 || p == 0) begin
      s_code   = digit_data[dig*DW +: DW];
      s_dp     = dp_in[dig];
      s_blank  = blank_mask[dig];
      s_blink  = blink_mask[dig];
      s_bright = int'(brightness);
    end
    lit = disp_en && !s_blank && !(s_blink && boff != 0) && (p != 0) &&
          ((p / (SLOT >> BW)) <= s_bright);
    an = '1;
    if (lit) an[dig] = 1'b0;
    di = 2'(dig);
    exp_q.push_back({di, an, ~(s_dp & lit), s_code});
    tag_q.push_back(k);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) step(rnd);
  endtask

  initial begin : monitor
    logic [11:0] e, act;
    int t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {scan_idx, anode, dp_out, data_out};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL cycle %0d: got idx=%0d an=%b dp=%b data=%0d want idx=%0d an=%b dp=%b data=%0d",
                   t, act[11:10], act[9:6], act[5], act[4:0], e[11:10], e[9:6], e[5], e[4:0]);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " anode"}, 32'(anode), 32'hF);
    check({tag, " dp_out"}, 32'(dp_out), 32'h1);
    check({tag, " data_out"}, 32'(data_out), 32'h0);
    check({tag, " scan_idx"}, 32'(scan_idx), 32'h3);
  endtask

  initial begin : main
    digit_data = 20'h0;
    #3 reset = 1'b1;   // no clock edge has happened yet
    #1 check_reset("rst0");
    repeat (2) @(negedge clk);

    brightness = 2'd3;
    digit_data = {5'd3, 5'd2, 5'd1, 5'd0};
    reset = 1'b0;
    k = 0;
    run(80, 1'b0);

    brightness = 2'd0;
    run(64, 1'b0);
    brightness = 2'd2;
    run(64, 1'b0);

    brightness = 2'd3;
    blink_mask = 4'b0001;
    blank_mask = 4'b0100;
    dp_in      = 4'b0100;
    run(128, 1'b0);

    blank_mask = 4'b0000;
    run(40, 1'b0);
    digit_data[14:10] = 5'd23;   // mid-slot change of digit 2
    run(70, 1'b0);

    disp_en = 1'b0;
    run(20, 1'b0);
    disp_en = 1'b1;

    run(640, 1'b1);

    @(posedge clk);
    #2;
    #1 reset = 1'b1;   // asynchronous, mid-slot
    #1 check_reset("rst1");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    run(300, 1'b1);

    @(posedge clk);
    #2;
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
